// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB, optional TRAP).
// Define ILLEGAL_TRAP_EN to trap illegal opcodes/func3 instead of running them as NOPs.
module cpu_ctrl_fsm #(
  parameter int         CNT_W       = 32,
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_b_sel,
  output logic [1:0]       imm_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic illegal_q, illegal_d;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, supported, bad;
  logic [1:0] imm_fmt;
  assign is_r      = opcode == OP_R;
  assign is_i      = opcode == OP_I;
  assign is_ld     = opcode == OP_LD;
  assign is_st     = opcode == OP_ST;
  assign is_br     = opcode == OP_BR;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign supported = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;
  assign bad = TRAP_EN & (~supported
             | (is_br & (func3 == 3'b010 | func3 == 3'b011))
             | (is_ld & (func3 == 3'b011 | func3[2:1] == 2'b11))
             | (is_st & (func3 > 3'b010))
             | (is_jalr & (func3 != 3'b000)));
  assign imm_fmt = is_st ? 2'd1 : is_br ? 2'd2 : is_jal ? 2'd3 : 2'd0;
  assign state       = state_q;
  assign retired_cnt = retired_cnt_q;
  assign illegal     = illegal_q;
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    alu_b_sel    = 1'b0;
    imm_sel      = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    retire       = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: state_d = EXEC;
        EXEC: begin
          imm_sel   = imm_fmt;
          alu_b_sel = supported & ~is_r;
          if (bad) begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end else if (is_ld | is_st) begin
            state_d = MEM;
          end else if (is_br | ~supported) begin
            pc_we   = 1'b1;
            pc_sel  = {1'b0, is_br & branch_taken};
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          imm_sel      = imm_fmt;
          alu_b_sel    = supported & ~is_r;
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_st;
          if (mem_ready) begin
            pc_we   = ~is_ld;
            retire  = ~is_ld;
            state_d = is_ld ? WB : FETCH;
          end
        end
        WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          wb_sel  = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
          pc_sel  = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
          state_d = FETCH;
        end
        TRAP: state_d = TRAP_EN ? TRAP : FETCH;
        default: state_d = FETCH;
      endcase
    end
  end
  assign retired_cnt_d = retired_cnt_q + CNT_W'(retire);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= state_t'(RESET_STATE);
      retired_cnt_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
      illegal_q     <= illegal_d;
    end
  end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm against an instruction-level sequence model.
module tb_cpu_ctrl_fsm;
  localparam int CW = 4;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_b_sel;
    logic [1:0] imm_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       retire;
  } ctrl_t;
  logic clk = 1'b0;
  logic rst, branch_taken, mem_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [2:0] state;
  logic ir_we, pc_we, rf_we, alu_b_sel, mem_req, mem_we, mem_addr_sel, retire, illegal;
  logic [1:0] pc_sel, wb_sel, imm_sel;
  logic [CW-1:0] retired_cnt;
  ctrl_t act, e_ctrl;
  logic [2:0] e_state;
  logic [CW-1:0] e_cnt, m_cnt;
  logic e_ill, m_ill;
  bit chk_en = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clk = ~clk;
  cpu_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .state(state), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_b_sel(alu_b_sel), .imm_sel(imm_sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .retire(retire),
    .retired_cnt(retired_cnt), .illegal(illegal)
  );
  assign act = {ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_b_sel, imm_sel,
                mem_req, mem_we, mem_addr_sel, retire};
  function automatic bit bad_instr(input logic [6:0] o, input logic [2:0] f);
    if (!TRAP_EN) return 1'b0;
    if (o == OP_R || o == OP_I || o == OP_JAL) return 1'b0;
    if (o == OP_BR) return f == 3'd2 || f == 3'd3;
    if (o == OP_LD) return f == 3'd3 || f >= 3'd6;
    if (o == OP_ST) return f > 3'd2;
    if (o == OP_JALR) return f != 3'd0;
    return 1'b1;
  endfunction
  function automatic ctrl_t model(input logic [2:0] st, input logic [6:0] o, input logic [2:0] f,
                                  input logic b, input logic rdy, input logic r);
    ctrl_t c;
    logic ld, sv, br, jl, jr, sup;
    c   = '0;
    ld  = o == OP_LD;
    sv  = o == OP_ST;
    br  = o == OP_BR;
    jl  = o == OP_JAL;
    jr  = o == OP_JALR;
    sup = o inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR};
    if (r) return c;
    if (st == 3'd2 || st == 3'd3) begin
      c.imm_sel   = sv ? 2'd1 : br ? 2'd2 : jl ? 2'd3 : 2'd0;
      c.alu_b_sel = sup && o != OP_R;
    end
    if (st == 3'd0) begin
      c.mem_req = 1'b1;
      c.ir_we   = rdy;
    end
    if (st == 3'd2 && !bad_instr(o, f) && (br || !sup)) begin
      c.pc_we  = 1'b1;
      c.pc_sel = (br && b) ? 2'd1 : 2'd0;
      c.retire = 1'b1;
    end
    if (st == 3'd3) begin
      c.mem_req      = 1'b1;
      c.mem_addr_sel = 1'b1;
      c.mem_we       = sv;
      c.pc_we        = rdy && !ld;
      c.retire       = rdy && !ld;
    end
    if (st == 3'd4) begin
      c.rf_we  = 1'b1;
      c.pc_we  = 1'b1;
      c.retire = 1'b1;
      c.wb_sel = ld ? 2'd1 : (jl || jr) ? 2'd2 : 2'd0;
      c.pc_sel = jl ? 2'd1 : jr ? 2'd2 : 2'd0;
    end
    return c;
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (state !== e_state) begin
        failures++;
        $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, e_state);
      end
      checks++;
      if (act !== e_ctrl) begin
        failures++;
        $display("FAIL ctrl t=%0t state=%0d got=%h exp=%h", $time, e_state, act, e_ctrl);
      end
      checks++;
      if (retired_cnt !== e_cnt) begin
        failures++;
        $display("FAIL retired_cnt t=%0t got=%0d exp=%0d", $time, retired_cnt, e_cnt);
      end
      checks++;
      if (illegal !== e_ill) begin
        failures++;
        $display("FAIL illegal t=%0t got=%0b exp=%0b", $time, illegal, e_ill);
      end
    end
  end
  task automatic step(input logic [2:0] st, input logic rdy);
    mem_ready = rdy;
    e_state   = st;
    e_ctrl    = model(st, opcode, func3, branch_taken, rdy, rst);
    e_cnt     = m_cnt;
    e_ill     = m_ill;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = '0;
      m_ill = 1'b0;
    end else begin
      if (e_ctrl.retire) m_cnt = m_cnt + 1'b1;
      if (st == 3'd2 && bad_instr(opcode, func3)) m_ill = 1'b1;
    end
  endtask
  task automatic run(input logic [6:0] o, input logic [2:0] f, input logic b,
                     input int fw, input int mw, output int cyc);
    logic [1:0] w;
    opcode = o;
    func3 = f;
    branch_taken = b;
    cyc = 0;
    repeat (fw) begin step(3'd0, 1'b0); cyc++; end
    step(3'd0, 1'b1);
    step(3'd1, 1'($urandom_range(0, 1)));
    step(3'd2, 1'($urandom_range(0, 1)));
    cyc += 3;
    if (bad_instr(o, f)) begin
      step(3'd5, 1'b1);
      step(3'd5, 1'b0);
      cyc += 2;
      return;
    end
    if (o == OP_LD || o == OP_ST) begin
      for (int i = 0; i < mw; i++) step(3'd3, 1'b0);
      step(3'd3, 1'b1);
      cyc += mw + 1;
    end
    if (o inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR}) begin
      w = 2'($urandom_range(0, 3));
      step(3'd4, w[0]);
      cyc++;
    end
  endtask
  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, a, e);
    end
  endtask
  task automatic reset_pulse();
    rst = 1'b1;
    step(state, 1'b1);
    step(3'd0, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    opcode = OP_R;
    func3 = 3'd0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    m_cnt = '0;
    m_ill = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(3'd0, 1'b1);
    step(3'd0, 1'b1);
    rst = 1'b0;
    lit("reset_state", 32'(state), 32'd0);
    lit("reset_cnt", 32'(retired_cnt), 32'd0);
    run(OP_R, 3'd0, 1'b0, 0, 0, n);
    lit("add_cycles", n, 4);
    lit("add_cnt", 32'(retired_cnt), 32'd1);
    run(OP_LD, 3'd2, 1'b0, 2, 1, n);
    lit("load_cycles", n, 8);
    lit("load_cnt", 32'(retired_cnt), 32'd2);
    run(OP_ST, 3'd2, 1'b0, 0, 0, n);
    lit("store_cycles", n, 4);
    run(OP_BR, 3'd0, 1'b1, 0, 0, n);
    lit("br_taken_cycles", n, 3);
    run(OP_BR, 3'd1, 1'b0, 0, 0, n);
    lit("br_not_cycles", n, 3);
    lit("branch_cnt", 32'(retired_cnt), 32'd5);
    run(OP_JALR, 3'd0, 1'b0, 0, 0, n);
    lit("jalr_cycles", n, 4);
    run(OP_JAL, 3'd5, 1'b1, 1, 0, n);
    lit("jal_cycles", n, 5);
    run(OP_I, 3'd7, 1'b0, 0, 0, n);
    lit("imm_cnt", 32'(retired_cnt), 32'd8);
    run(OP_SYS, 3'd0, 1'b0, 0, 0, n);
    if (TRAP_EN) begin
      lit("trap_state", 32'(state), 32'd5);
      lit("trap_illegal", 32'(illegal), 32'd1);
      lit("trap_cnt", 32'(retired_cnt), 32'd8);
    end else begin
      lit("nop_cycles", n, 3);
      lit("nop_cnt", 32'(retired_cnt), 32'd9);
    end
    reset_pulse();
    lit("after_rst_cnt", 32'(retired_cnt), 32'd0);
    opcode = OP_LD;
    func3 = 3'd0;
    step(3'd0, 1'b1);
    step(3'd1, 1'b1);
    step(3'd2, 1'b1);
    step(3'd3, 1'b0);
    rst = 1'b1;
    step(3'd3, 1'b1);
    lit("mem_abort_state", 32'(state), 32'd0);
    step(3'd0, 1'b1);
    rst = 1'b0;
    lit("mem_abort_cnt", 32'(retired_cnt), 32'd0);
    run(OP_ST, 3'd1, 1'b0, 1, 2, n);
    lit("store_wait_cycles", n, 7);
    for (int i = 0; i < 17; i++) run(OP_BR, 3'd4, 1'($urandom_range(0, 1)), 0, 0, n);
    lit("cnt_wrap", 32'(retired_cnt), 32'd2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
